// File: rtl/dmem_responder.sv
// CPU data-memory responder: one request at a time, turned into a fixed-length
// asynchronous-SRAM access with byte-lane steering and load sign/zero extension.
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [1:0]         req_sel,
  input  logic               req_uns,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic [1:0]         dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // a response transfers on a rising edge with resp_valid && resp_ready.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          sel_q, sel_d;
  logic                uns_q, uns_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic [3:0]          be_n_q, be_n_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [31:0]         sram_wdata_q, sram_wdata_d;

  logic                req_illegal;
  logic [3:0]          lane_mask;
  logic [31:0]         wdata_rep;
  logic [31:0]         load_val;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  always_comb begin
    req_illegal = (req_sel == 2'b11) ||
                  (req_sel == 2'b01 && req_addr[0]) ||
                  (req_sel == 2'b00 && req_addr[1:0] != 2'b00);
    lane_mask = 4'b1111;
    wdata_rep = req_wdata;
    case (req_sel)
      2'b10: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction from the word the SRAM returns in the last access cycle.
  always_comb begin
    ld_byte = sram_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = sram_rdata[15:8];
      2'd2:    ld_byte = sram_rdata[23:16];
      2'd3:    ld_byte = sram_rdata[31:24];
      default: ;
    endcase
    ld_half  = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    load_val = sram_rdata;
    if (sel_q == 2'b10) begin
      load_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
    end else if (sel_q == 2'b01) begin
      load_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    off_d        = off_q;
    sel_d        = sel_q;
    uns_d        = uns_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ce_n_d       = ce_n_q;
    we_n_d       = we_n_q;
    be_n_d       = be_n_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          off_d = req_addr[1:0];
          sel_d = req_sel;
          uns_d = req_uns;
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d      = S_ACCESS;
            cnt_d        = 4'(WAIT_CYCLES);
            ce_n_d       = 1'b0;
            we_n_d       = ~req_we;
            be_n_d       = req_we ? ~lane_mask : 4'b0000;
            sram_addr_d  = req_addr[SRAM_AW+1:2];
            sram_wdata_d = req_we ? wdata_rep : sram_wdata_q;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          ce_n_d       = 1'b1;
          we_n_d       = 1'b1;
          be_n_d       = 4'b1111;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      off_q        <= 2'd0;
      sel_q        <= 2'd0;
      uns_q        <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= 4'b1111;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      off_q        <= off_d;
      sel_q        <= sel_d;
      uns_q        <= uns_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ce_n_q       <= ce_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, randomized transactions
// against a size/offset arithmetic model, and an abort-by-reset sequence.
module tb_dmem_responder;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic [1:0]    req_sel = 2'b00;
  logic          req_uns = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_responder #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel), .req_uns(req_uns),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sizes and lane offsets with plain arithmetic.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sel, input logic uns, input logic [31:0] rdata,
                       output logic err, output logic [31:0] rd,
                       output logic [3:0] be, output logic [31:0] wd);
    int size;
    int off;
    longint v;
    size = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 1;
    off  = int'(addr % 4);
    err  = (sel == 2'd3) || ((addr % size) != 0);
    be   = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (!we || (k >= off && k < off + size)) be[k] = 1'b0;
      wd[8*k +: 8] = wdata[8*(k % size) +: 8];
    end
    v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
    if (!uns && ((v >> (8 * size - 1)) & 1) == 1) v = v - (64'd1 << (8 * size));
    rd = (we || err) ? 32'h0 : v[31:0];
  endtask

  // Driver: one full transaction with per-cycle protocol checks.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] sel, input logic uns, input logic [31:0] rdata,
                        input int resp_delay,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int k;
    int acc;
    logic [AW-1:0] exp_sa;
    exp_sa = AW'((addr >> 2) & ((32'd1 << AW) - 1));
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_sel = sel; req_uns = uns;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_sel = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
    k = 1; acc = 0;
    while (!resp_valid && k < 64) begin
      acc++;
      chk("access_ce_n", 32'(sram_ce_n), 32'd0);
      chk("access_we_n", 32'(sram_we_n), 32'(!we));
      chk("access_be_n", 32'(sram_be_n), 32'(exp_be));
      chk("access_addr", 32'(sram_addr), 32'(exp_sa));
      if (we) chk("access_wdata", sram_wdata, exp_wd);
      chk("access_req_ready", 32'(req_ready), 32'd0);
      sram_rdata = (k == W + 1) ? rdata : $urandom;
      req_valid  = 1'($urandom_range(0, 1));
      resp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), exp_err ? 32'd1 : 32'(W + 2));
    chk("access_cycles", 32'(acc), exp_err ? 32'd0 : 32'(W + 1));
    for (int i = 0; i <= resp_delay; i++) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      chk("resp_ce_n", 32'(sram_ce_n), 32'd1);
      chk("resp_we_n", 32'(sram_we_n), 32'd1);
      chk("resp_be_n", 32'(sram_be_n), 32'hF);
      if (!exp_err) chk("resp_addr_hold", 32'(sram_addr), 32'(exp_sa));
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      sram_rdata = $urandom;
      resp_ready = (i == resp_delay);
      @(posedge clk); #1;
    end
    chk("after_resp_valid", 32'(resp_valid), 32'd0);
    chk("after_req_ready", 32'(req_ready), 32'd1);
    chk("after_state", 32'(dbg_state), 32'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic        uns;
    logic [31:0] rdata;
    int          delay;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[10];

  // Scoreboard for random traffic: expected read data, one entry per request.
  logic [31:0] exp_q[$];

  initial begin
    logic        m_err;
    logic [31:0] m_rd;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_sel;
    logic        r_uns;
    logic [31:0] r_rdata;

    vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_1003, 32'h0,         2'b10, 1'b0, 32'h8012_3456, 1, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_1003, 32'h0,         2'b10, 1'b1, 32'h8012_3456, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,         2, 1'b0, 32'h0,         4'b0011, 32'hABCD_ABCD};
    vecs[4] = '{1'b0, 32'h0000_3001, 32'h0,         2'b00, 1'b0, 32'h1234_5678, 0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0040, 32'h0,         2'b00, 1'b0, 32'hCAFE_F00D, 5, 1'b0, 32'hCAFE_F00D, 4'b0000, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_0011, 32'h0000_005A, 2'b10, 1'b0, 32'h0,         0, 1'b0, 32'h0,         4'b1101, 32'h5A5A_5A5A};
    vecs[7] = '{1'b0, 32'h0000_0022, 32'h0,         2'b01, 1'b0, 32'h8001_1234, 0, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0};
    vecs[8] = '{1'b1, 32'h0000_0020, 32'h0,         2'b11, 1'b0, 32'h0,         1, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[9] = '{1'b1, 32'h0030_0008, 32'h1357_9BDF, 2'b00, 1'b0, 32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h1357_9BDF};

    // Reset state
    #12;
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed table
    for (int v = 0; v < 10; v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sel, vecs[v].uns,
             vecs[v].rdata, vecs[v].delay,
             vecs[v].exp_err, vecs[v].exp_rd, vecs[v].exp_be, vecs[v].exp_wd);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_sel   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) begin
        r_addr = (r_sel == 2'b00) ? {r_addr[31:2], 2'b00} :
                 (r_sel == 2'b01) ? {r_addr[31:1], 1'b0} : r_addr;
      end
      r_uns   = 1'($urandom_range(0, 1));
      r_rdata = $urandom;
      model(r_we, r_addr, r_wdata, r_sel, r_uns, r_rdata, m_err, m_rd, m_be, m_wd);
      exp_q.push_back(m_rd);
      do_txn(r_we, r_addr, r_wdata, r_sel, r_uns, r_rdata, $urandom_range(0, 3),
             m_err, exp_q.pop_front(), m_be, m_wd);
    end

    // Abort by reset in the second access cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0104; req_sel = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    chk("abort_pre_ce_n", 32'(sram_ce_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort_be_n", 32'(sram_be_n), 32'hF);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_sram_addr", 32'(sram_addr), 32'h0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_rdata", resp_rdata, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2 (range 0..15), extra SRAM access cycles beyond the first.
REQ-002 Parameter SRAM_AW, default 20, SRAM word-address width.
REQ-003 Reset is asynchronous and active-low; the block has one clock.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  CPU memory request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1=store, 0=load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_sel  input  2  size: 00 word, 01 half, 10 byte, 11 illegal.
REQ-012 req_uns  input  1  load zero-extends when 1, sign-extends when 0.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  CPU accepts response.
REQ-015 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-016 resp_err  output  1  request was misaligned or illegal.
REQ-017 sram_ce_n  output  1  SRAM chip enable, active-low.
REQ-018 sram_we_n  output  1  SRAM write enable, active-low.
REQ-019 sram_be_n  output  4  byte-lane enables, active-low, lane k = bits [8k+7:8k].
REQ-020 sram_addr  output  SRAM_AW  word address = req_addr[SRAM_AW+1:2].
REQ-021 sram_wdata  output  32  lane-replicated store data.
REQ-022 sram_rdata  input  32  SRAM read data, valid in last ACCESS cycle.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-024 IDLE: req_valid=1 accepts; latch we/addr/wdata/sel/uns; legal -> ACCESS, illegal -> RESP with resp_err=1.
REQ-025 Illegal: sel=11; sel=01 with addr[0]=1; sel=00 with addr[1:0]!=0; no SRAM strobe issued.
REQ-026 ACCESS lasts exactly WAIT_CYCLES+1 cycles via down-counter loaded with WAIT_CYCLES; sram_ce_n=0 throughout.
REQ-027 Store: sram_we_n=0 for all ACCESS cycles; byte lane addr[1:0] enabled, wdata[7:0] replicated x4; half lanes {addr[1]*2+1, addr[1]*2}, wdata[15:0] replicated x2; word all lanes.
REQ-028 Load: sram_we_n=1, sram_be_n=0000; sram_rdata captured at the final ACCESS edge.
REQ-029 Load extract: byte = lane addr[1:0], half = bits [16*addr[1]+15:16*addr[1]], extended per req_uns.
REQ-030 ACCESS end -> RESP; resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1.
REQ-031 RESP with resp_ready=1 -> IDLE next cycle; no new request accepted in the same cycle.
REQ-032 Latency, legal request: accept edge to resp_valid high = WAIT_CYCLES+2 cycles; illegal: 1 cycle.
REQ-033 Outside ACCESS: sram_ce_n=1, sram_we_n=1, sram_be_n=1111; sram_addr/sram_wdata hold last values.
REQ-034 req_* inputs are ignored outside IDLE; resp_ready is ignored outside RESP.

Reset
REQ-035 rst=0 immediately forces IDLE, counter 0, req_ready=1 (after release), resp_valid=0, resp_rdata=0, resp_err=0, sram_ce_n=1, sram_we_n=1, sram_be_n=1111, sram_addr=0, sram_wdata=0.
REQ-036 Reset during ACCESS or RESP aborts the transaction; no response is delivered for it.

Verification
REQ-037 Word load, WAIT_CYCLES=2, addr=0x00000104, sram_rdata=0xDEADBEEF -> sram_addr=0x41, 3 ACCESS cycles, resp_valid 4 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-038 Signed byte load addr=0x...03, sram_rdata=0x80123456, uns=0 -> rdata=0xFFFFFF80; uns=1 -> 0x00000080.
REQ-039 Half store addr=0x...02, wdata=0x0000ABCD -> sram_be_n=0011, sram_wdata=0xABCDABCD, sram_we_n=0 during ACCESS, resp rdata=0, err=0.
REQ-040 Misaligned word load addr=0x...01 -> sram_ce_n stays 1, resp_valid next cycle, err=1, rdata=0.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid, rdata held stable, req_ready=0, new req_valid ignored.
REQ-042 rst=0 asserted in 2nd ACCESS cycle -> sram_ce_n=1 asynchronously; after release, resp_valid=0, req_ready=1.
